// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : Hazard/flush controller for the 5-stage RV32I pipeline.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dec_valid,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic              ex_valid,
  input  logic [4:0]        ex_rd,
  input  logic              ex_is_load,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              br_resolve,
  input  logic              br_mispredict,
  input  logic [12:0]       br_target,
  input  logic              hit_predict,
  output logic              stall,
  output logic              stall_all,
  output logic              fail_predict,
  output logic              hit_flush,
  output logic              ex_bubble,
  output logic              redirect_valid,
  output logic [12:0]       redirect_pc,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  mispred_cnt,
  output logic              mem_timeout
);

  localparam int              c_WAIT_W     = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX   = c_WAIT_W'(MEM_TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST  = c_WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [1:0]      c_FLUSH_INIT = 2'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_MEMWAIT = 2'b01,
    ST_FLUSH   = 2'b10
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_flush_cnt, w_flush_nxt;
  logic [c_WAIT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]      r_stall_cnt, r_mispred_cnt;
  logic                  r_mem_timeout;

  logic w_lu, w_mp, w_mw;
  logic w_stall, w_stall_all, w_fail, w_bubble, w_redirect;

  assign w_lu = dec_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                ((dec_use_rs1 & (dec_rs1 == ex_rd)) | (dec_use_rs2 & (dec_rs2 == ex_rd)));
  assign w_mp = br_resolve & br_mispredict & (r_state == ST_RUN);
  assign w_mw = mem_req & ~mem_ready;

  always_comb begin
    w_stall     = 1'b0;
    w_stall_all = 1'b0;
    w_fail      = 1'b0;
    w_bubble    = 1'b0;
    w_redirect  = 1'b0;
    w_state_nxt = r_state;
    w_flush_nxt = r_flush_cnt;
    if (!RST) begin
      case (r_state)
        ST_RUN: begin
          if (w_mw) begin
            w_stall     = 1'b1;
            w_stall_all = 1'b1;
            w_state_nxt = ST_MEMWAIT;
          end else if (w_mp) begin
            w_fail     = 1'b1;
            w_redirect = 1'b1;
            if (c_FLUSH_INIT != 2'd0) begin
              w_state_nxt = ST_FLUSH;
              w_flush_nxt = c_FLUSH_INIT;
            end
          end else if (w_lu) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
          end
        end
        ST_MEMWAIT: begin
          // Dropping mem_req without ready releases the wait the same way as ready.
          if (w_mw) begin
            w_stall     = 1'b1;
            w_stall_all = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (w_mw) begin
            w_stall     = 1'b1;
            w_stall_all = 1'b1;
            w_state_nxt = ST_MEMWAIT;
            w_flush_nxt = 2'd0;
          end else begin
            w_fail = 1'b1;
            if (r_flush_cnt <= 2'd1) begin
              w_state_nxt = ST_RUN;
              w_flush_nxt = 2'd0;
            end else begin
              w_flush_nxt = r_flush_cnt - 2'd1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_flush_nxt = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= ST_RUN;
      r_flush_cnt   <= 2'd0;
      r_wait_cnt    <= '0;
      r_stall_cnt   <= '0;
      r_mispred_cnt <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_nxt;
      if (w_mw) begin
        if (r_wait_cnt != c_WAIT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
        if (r_wait_cnt >= c_WAIT_LAST) r_mem_timeout <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_redirect && (r_mispred_cnt != {CNT_W{1'b1}}))
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
    end
  end

  assign stall          = w_stall;
  assign stall_all      = w_stall_all;
  assign fail_predict   = w_fail;
  assign ex_bubble      = w_bubble;
  assign redirect_valid = w_redirect;
  assign redirect_pc    = w_redirect ? br_target : 13'd0;
  assign hit_flush      = hit_predict & ~RST & ~w_stall & ~w_fail;
  assign state          = r_state;
  assign stall_cnt      = r_stall_cnt;
  assign mispred_cnt    = r_mispred_cnt;
  assign mem_timeout    = r_mem_timeout;

endmodule
`default_nettype wire
